// File: rtl/spi_master_if.sv
// Host-side byte stream and SPI pins of the demoscene SPI controller.
// The master modport is the controller's view; slave is the host/pin side.
interface spi_master_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       SCLK;
    logic       SSEL;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  tx_data, tx_valid, tx_last, MISO,
        output tx_ready, rx_data, rx_valid, busy, SCLK, SSEL, MOSI
    );

    modport slave (
        output tx_data, tx_valid, tx_last, MISO,
        input  tx_ready, rx_data, rx_valid, busy, SCLK, SSEL, MOSI
    );
endinterface

// File: rtl/spi_master.sv
// SPI master: SCLK idles low, MOSI launched on SCLK fall, MISO captured on SCLK fall.
// SSEL is active-high and stays asserted across back-to-back bytes of one frame.
module spi_master #(
    parameter int CLK_DIV = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEAD  = 3'd1;
    localparam logic [2:0] HIGH  = 3'd2;
    localparam logic [2:0] LOW   = 3'd3;
    localparam logic [2:0] NEXT  = 3'd4;
    localparam logic [2:0] TRAIL = 3'd5;
    localparam logic [2:0] GAP   = 3'd6;

    logic [2:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [6:0]       tx_shift;
    logic [6:0]       rx_shift;
    logic             last_byte;
    logic             sclk_q;
    logic             ssel_q;
    logic             mosi_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;

    logic       accept;
    logic       timed;
    logic       div_done;
    logic [7:0] rx_next;

    assign bus.tx_ready = (state == IDLE) || (state == NEXT);
    assign bus.busy     = (state != IDLE);
    assign bus.SCLK     = sclk_q;
    assign bus.SSEL     = ssel_q;
    assign bus.MOSI     = mosi_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

    assign accept   = bus.tx_valid && bus.tx_ready;
    assign timed    = (state == LEAD) || (state == HIGH) || (state == LOW) ||
                      (state == TRAIL) || (state == GAP);
    assign div_done = (div_cnt == DIV_LAST);
    assign rx_next  = {rx_shift, bus.MISO};

    // Every timed state starts with div_cnt at zero, so each lasts exactly CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= 3'd0;
            tx_shift   <= 7'd0;
            rx_shift   <= 7'd0;
            last_byte  <= 1'b0;
            sclk_q     <= 1'b0;
            ssel_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (timed && !div_done) begin
                div_cnt <= div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_shift  <= bus.tx_data[6:0];
                        last_byte <= bus.tx_last;
                        mosi_q    <= bus.tx_data[7];
                        ssel_q    <= 1'b1;
                        bit_cnt   <= 3'd0;
                        state     <= LEAD;
                    end
                end
                LEAD: begin
                    if (div_done) begin
                        sclk_q <= 1'b1;
                        state  <= HIGH;
                    end
                end
                // The falling edge both captures MISO and launches the next MOSI bit.
                HIGH: begin
                    if (div_done) begin
                        sclk_q   <= 1'b0;
                        rx_shift <= rx_next[6:0];
                        if (bit_cnt != 3'd7) begin
                            mosi_q   <= tx_shift[6];
                            tx_shift <= {tx_shift[5:0], 1'b0};
                            bit_cnt  <= bit_cnt + 3'd1;
                            state    <= LOW;
                        end else begin
                            rx_data_q  <= rx_next;
                            rx_valid_q <= 1'b1;
                            state      <= last_byte ? TRAIL : NEXT;
                        end
                    end
                end
                LOW: begin
                    if (div_done) begin
                        sclk_q <= 1'b1;
                        state  <= HIGH;
                    end
                end
                // Frame held open with SCLK parked low until the host supplies another byte.
                NEXT: begin
                    if (accept) begin
                        tx_shift  <= bus.tx_data[6:0];
                        last_byte <= bus.tx_last;
                        mosi_q    <= bus.tx_data[7];
                        bit_cnt   <= 3'd0;
                        state     <= LOW;
                    end
                end
                TRAIL: begin
                    if (div_done) begin
                        ssel_q <= 1'b0;
                        state  <= GAP;
                    end
                end
                GAP: begin
                    if (div_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    sclk_q <= 1'b0;
                    ssel_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Randomized scoreboard bench for spi_master, run at CLK_DIV=2 and CLK_DIV=1 side by side.
// A pin-level slave model checks MOSI bytes and frame timing; a monitor checks rx_data.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;
    int doneCount   = 0;

    typedef struct {
        logic [7:0] data;
        logic [7:0] resp;
        bit         last;
        int         stall;
    } item_t;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic noteFail(input string name, input string what);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: got %s", name, what);
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_div
        localparam int DIV = (g == 0) ? 2 : 1;

        logic rst;
        spi_master_if bus ();

        spi_master #(.CLK_DIV(DIV)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        logic [7:0] expTxQ[$];
        logic [7:0] expRxQ[$];
        logic [7:0] respQ[$];
        int         expRiseQ[$];
        item_t      items[$];

        // Slave model: samples MOSI at each SCLK rise, drives MISO MSB first after the rise.
        int         bitIdx     = 0;
        int         frameRises = 0;
        int         sinceRise  = 0;
        int         sinceFall  = 0;
        logic       prevSclk   = 1'b0;
        logic       prevSsel   = 1'b0;
        logic [7:0] curResp    = 8'h00;
        logic [7:0] mosiSh     = 8'h00;

        always @(negedge clk) begin
            if (rst) begin
                bitIdx     = 0;
                frameRises = 0;
                bus.MISO   = 1'b0;
                prevSclk   = bus.SCLK;
                prevSsel   = bus.SSEL;
            end else begin
                sinceRise++;
                sinceFall++;
                if (bus.SCLK && !prevSclk) begin
                    checkOutput($sformatf("div%0d SSEL at rise", DIV), int'(bus.SSEL), 1);
                    if (bitIdx == 0) begin
                        curResp = (respQ.size() > 0) ? respQ.pop_front() : 8'h00;
                    end else begin
                        checkOutput($sformatf("div%0d rise spacing", DIV), sinceRise, 2 * DIV);
                    end
                    mosiSh   = {mosiSh[6:0], bus.MOSI};
                    bus.MISO = curResp[7 - bitIdx];
                    bitIdx++;
                    frameRises++;
                    sinceRise = 0;
                    if (bitIdx == 8) begin
                        bitIdx = 0;
                        if (expTxQ.size() == 0)
                            noteFail($sformatf("div%0d MOSI byte", DIV), "an unexpected byte");
                        else
                            checkOutput($sformatf("div%0d MOSI byte", DIV), int'(mosiSh),
                                        int'(expTxQ.pop_front()));
                    end
                end
                if (!bus.SCLK && prevSclk) sinceFall = 0;
                if (!bus.SSEL && prevSsel) begin
                    checkOutput($sformatf("div%0d trail length", DIV), sinceFall, DIV);
                    if (expRiseQ.size() == 0)
                        noteFail($sformatf("div%0d frame rises", DIV), "an unexpected frame end");
                    else
                        checkOutput($sformatf("div%0d frame rises", DIV), frameRises,
                                    expRiseQ.pop_front());
                    frameRises = 0;
                    bitIdx     = 0;
                end
                prevSclk = bus.SCLK;
                prevSsel = bus.SSEL;
            end
        end

        // Monitor: every rx_valid pulse must match the next queued slave response.
        always @(negedge clk) begin
            if (!rst && bus.rx_valid) begin
                if (expRxQ.size() == 0)
                    noteFail($sformatf("div%0d rx_valid", DIV), "an unexpected pulse");
                else
                    checkOutput($sformatf("div%0d rx_data", DIV), int'(bus.rx_data),
                                int'(expRxQ.pop_front()));
            end
        end

        // Stimulus: directed frames first, then random frames, a mid-byte reset, more frames.
        initial begin : applyStimulus
            int    waitCnt;
            int    lat;
            int    nb;
            int    n;
            int    rises;
            bit    ok;
            logic  prevS;
            item_t it;

            rst          = 1'b1;
            bus.tx_valid = 1'b0;
            bus.tx_data  = 8'h00;
            bus.tx_last  = 1'b0;
            repeat (3) @(negedge clk);
            checkOutput($sformatf("div%0d reset tx_ready", DIV), int'(bus.tx_ready), 1);
            checkOutput($sformatf("div%0d reset busy", DIV), int'(bus.busy), 0);
            checkOutput($sformatf("div%0d reset SCLK", DIV), int'(bus.SCLK), 0);
            checkOutput($sformatf("div%0d reset SSEL", DIV), int'(bus.SSEL), 0);
            checkOutput($sformatf("div%0d reset MOSI", DIV), int'(bus.MOSI), 0);
            checkOutput($sformatf("div%0d reset rx_data", DIV), int'(bus.rx_data), 0);
            rst = 1'b0;
            @(negedge clk);

            for (int phase = 0; phase < 2; phase++) begin
                items.delete();
                if (phase == 0) begin
                    it = '{8'hA5, 8'hA5, 1'b1, 0};             items.push_back(it);
                    it = '{8'h01, 8'($urandom), 1'b0, 0};      items.push_back(it);
                    it = '{8'h2A, 8'($urandom), 1'b0, 0};      items.push_back(it);
                    it = '{8'h01, 8'($urandom), 1'b1, 0};      items.push_back(it);
                    it = '{8'h5A, 8'hFF, 1'b0, 0};             items.push_back(it);
                    it = '{8'hC3, 8'h00, 1'b1, 10};            items.push_back(it);
                end else begin
                    it = '{8'h3C, 8'h3C, 1'b1, 0};             items.push_back(it);
                end
                for (int f = 0; f < ((phase == 0) ? 10 : 2); f++) begin
                    n = $urandom_range(1, 4);
                    for (int b = 0; b < n; b++) begin
                        it.data  = 8'($urandom);
                        it.resp  = 8'($urandom);
                        it.last  = (b == n - 1);
                        it.stall = (b > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
                        items.push_back(it);
                    end
                end

                for (int i = 0; i <= items.size(); i++) begin
                    // Deselect time: GAP must hold busy for exactly DIV cycles after SSEL drops.
                    if (i == items.size() || (i > 0 && items[i-1].last)) begin
                        waitCnt = 0;
                        while (bus.SSEL && waitCnt < 2000) begin
                            @(negedge clk);
                            waitCnt++;
                        end
                        n = 0;
                        while (bus.busy && n < 100) begin
                            @(negedge clk);
                            n++;
                        end
                        checkOutput($sformatf("div%0d gap length", DIV), n, DIV);
                        if (i == items.size()) break;
                    end

                    if (i == 0 || items[i-1].last) begin
                        nb = 0;
                        for (int j = i; j < items.size(); j++) begin
                            nb++;
                            if (items[j].last) break;
                        end
                        expRiseQ.push_back(8 * nb);
                    end
                    expTxQ.push_back(items[i].data);
                    expRxQ.push_back(items[i].resp);
                    respQ.push_back(items[i].resp);

                    if (items[i].stall > 0) begin
                        bus.tx_valid = 1'b0;
                        waitCnt = 0;
                        while (!bus.tx_ready && waitCnt < 400) begin
                            @(negedge clk);
                            waitCnt++;
                        end
                        ok = 1'b1;
                        for (int k = 0; k < items[i].stall; k++) begin
                            if (bus.SCLK !== 1'b0 || bus.SSEL !== 1'b1 || bus.tx_ready !== 1'b1)
                                ok = 1'b0;
                            @(negedge clk);
                        end
                        checkOutput($sformatf("div%0d stall hold", DIV), int'(ok), 1);
                    end

                    bus.tx_data  = items[i].data;
                    bus.tx_last  = items[i].last;
                    bus.tx_valid = 1'b1;
                    waitCnt = 0;
                    while (!bus.tx_ready && waitCnt < 400) begin
                        @(negedge clk);
                        waitCnt++;
                    end
                    if (waitCnt >= 400) noteFail($sformatf("div%0d tx_ready wait", DIV), "a timeout");
                    @(posedge clk);
                    @(negedge clk);
                    bus.tx_valid = 1'b0;
                    lat = 0;
                    while (!bus.SCLK && lat < 100) begin
                        @(negedge clk);
                        lat++;
                    end
                    checkOutput($sformatf("div%0d first rise latency", DIV), lat, DIV);
                end

                if (phase == 0) begin
                    // Abort a byte after its third SCLK rise; nothing may be reported for it.
                    respQ.push_back(8'($urandom));
                    bus.tx_data  = 8'($urandom);
                    bus.tx_last  = 1'b1;
                    bus.tx_valid = 1'b1;
                    waitCnt = 0;
                    while (!bus.tx_ready && waitCnt < 400) begin
                        @(negedge clk);
                        waitCnt++;
                    end
                    @(posedge clk);
                    @(negedge clk);
                    bus.tx_valid = 1'b0;
                    rises   = 0;
                    prevS   = 1'b0;
                    waitCnt = 0;
                    while (rises < 3 && waitCnt < 200) begin
                        if (bus.SCLK && !prevS) rises++;
                        prevS = bus.SCLK;
                        if (rises < 3) @(negedge clk);
                        waitCnt++;
                    end
                    rst = 1'b1;
                    @(negedge clk);
                    checkOutput($sformatf("div%0d abort SCLK", DIV), int'(bus.SCLK), 0);
                    checkOutput($sformatf("div%0d abort SSEL", DIV), int'(bus.SSEL), 0);
                    checkOutput($sformatf("div%0d abort MOSI", DIV), int'(bus.MOSI), 0);
                    checkOutput($sformatf("div%0d abort tx_ready", DIV), int'(bus.tx_ready), 1);
                    checkOutput($sformatf("div%0d abort busy", DIV), int'(bus.busy), 0);
                    checkOutput($sformatf("div%0d abort rx_valid", DIV), int'(bus.rx_valid), 0);
                    @(negedge clk);
                    rst = 1'b0;
                    respQ.delete();
                    repeat (2) @(negedge clk);
                end
            end

            repeat (4) @(negedge clk);
            checkOutput($sformatf("div%0d MOSI bytes left", DIV), expTxQ.size(), 0);
            checkOutput($sformatf("div%0d rx bytes left", DIV), expRxQ.size(), 0);
            checkOutput($sformatf("div%0d frames left", DIV), expRiseQ.size(), 0);
            doneCount++;
        end
    end

    initial begin : checkOutputSummary
        int cycles;
        cycles = 0;
        while (doneCount != 2 && cycles < 60000) begin
            @(posedge clk);
            cycles++;
        end
        if (doneCount != 2) noteFail("watchdog", "a stimulus timeout");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
